// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - nibble-serial WIDTH-bit adder sequencer around an external 4-bit adder
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_s,
    input  logic             add_cout
);

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               carry_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [IDX_W+1:0]   bit_base;

    // Bit offset of the nibble currently on the adder; idx never exceeds N-1.
    assign bit_base = {idx, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= op_a;
                        b_reg     <= op_b;
                        carry_reg <= cin;
                        idx       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum[bit_base +: 4] <= add_s;
                    carry_reg          <= add_cout;
                    if (idx == LAST_IDX) begin
                        cout  <= add_cout;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The adder sees operands only while running; otherwise its inputs are parked at zero.
    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_reg[bit_base +: 4];
            add_b   = b_reg[bit_base +: 4];
            add_cin = carry_reg;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - self-checking bench for nibble_serial_add_ctrl with a 4-bit adder attached
module tb_nibble_serial_add_ctrl;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_s;
    logic             add_cout;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             c;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
        logic [N-1:0]     exp_cins;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            passes++;
    endtask

    // Carry into nibble k is whatever overflows out of the low 4k bits of a + b + cin.
    function automatic logic [N-1:0] model_cins(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic c);
        logic [N-1:0] r;
        longint unsigned mask;
        for (int k = 0; k < N; k++) begin
            mask = (64'd1 << (4 * k)) - 1;
            r[k] = (((a & mask) + (b & mask) + c) >> (4 * k)) != 0;
        end
        return r;
    endfunction

    // Issues one addition and checks the per-nibble adder drive, done timing and result.
    task automatic run_add(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic c, input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                           input logic [N-1:0] exp_cins);
        logic [WIDTH-1:0] aseq, bseq;
        logic [N-1:0]     cseq;
        logic             early_done;
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; cin = c;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op_a = $urandom; op_b = $urandom; cin = 1'($urandom);
        early_done = 1'b0;
        for (int k = 0; k < N; k++) begin
            aseq[4*k +: 4] = add_a;
            bseq[4*k +: 4] = add_b;
            cseq[k]        = add_cin;
            early_done     = early_done | done | ~busy;
            @(negedge clk);
        end
        chk({tag, " add_a seq"}, 32'(aseq), 32'(a));
        chk({tag, " add_b seq"}, 32'(bseq), 32'(b));
        chk({tag, " add_cin seq"}, 32'(cseq), 32'(exp_cins));
        chk({tag, " run no done"}, 32'(early_done), 32'd0);
        chk({tag, " done at T+N"}, 32'({done, busy}), 32'b11);
        chk({tag, " sum"}, 32'(sum), 32'(exp_sum));
        chk({tag, " cout"}, 32'(cout), 32'(exp_cout));
        @(negedge clk);
        chk({tag, " idle after done"}, 32'({done, busy, add_a, add_b, add_cin}), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        logic [WIDTH:0] ref_full;
        logic [WIDTH-1:0] ra, rb;
        logic rc;
        int first_done, accept2, second_done;
        logic [WIDTH-1:0] sum_at_done1;
        logic cout_at_done1;
        logic done_seen;

        vecs[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 4'b0000};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4'b1110};
        vecs[2] = '{16'h7FFF, 16'h8000, 1'b1, 16'h0000, 1'b1, 4'b1111};
        vecs[3] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 4'b1111};
        vecs[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'b0000};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 4'b1111};

        rst_n = 1'b0;
        start = 1'($urandom); op_a = $urandom; op_b = $urandom; cin = 1'($urandom);
        repeat (3) @(negedge clk);
        chk("reset busy/done", 32'({busy, done}), 32'd0);
        chk("reset sum/cout", 32'({cout, sum}), 32'd0);
        chk("reset adder drive", 32'({add_a, add_b, add_cin}), 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_add($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c,
                    vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_cins);

        for (int i = 0; i < 30; i++) begin
            ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
            ref_full = (WIDTH+1)'(ra) + (WIDTH+1)'(rb) + (WIDTH+1)'(rc);
            run_add($sformatf("rand%0d", i), ra, rb, rc, ref_full[WIDTH-1:0], ref_full[WIDTH],
                    model_cins(ra, rb, rc));
        end

        // Start while busy is ignored; start held afterwards is taken N+2 cycles after the first.
        @(negedge clk);
        start = 1'b1; op_a = 16'h0005; op_b = 16'h0003; cin = 1'b0;
        @(posedge clk);
        first_done = -1; accept2 = -1; second_done = -1;
        sum_at_done1 = '0; cout_at_done1 = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) begin op_a = 16'hFFFF; op_b = 16'hFFFF; cin = 1'b0; end
            if (done && first_done < 0) begin
                first_done = n; sum_at_done1 = sum; cout_at_done1 = cout;
            end else if (done && second_done < 0) begin
                second_done = n;
            end
            if (first_done > 0 && accept2 < 0 && busy && !done) accept2 = n;
            if (n == 8) start = 1'b0;
        end
        chk("busy start ignored sum", 32'(sum_at_done1), 32'h0008);
        chk("busy start ignored cout", 32'(cout_at_done1), 32'd0);
        chk("first done timing", 32'(first_done), 32'(N + 1));
        chk("held start reaccept", 32'(accept2), 32'(N + 3));
        chk("second done timing", 32'(second_done), 32'(2 * N + 3));
        chk("second result", 32'({cout, sum}), 32'h1FFFE);

        // Reset during the second RUN cycle aborts the addition with no done pulse.
        @(negedge clk);
        start = 1'b1; op_a = 16'h1234; op_b = 16'h1111; cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre-abort nibble0", 32'(sum[3:0]), 32'h5);
        rst_n = 1'b0;
        #1;
        chk("abort busy/done", 32'({busy, done}), 32'd0);
        chk("abort sum/cout", 32'({cout, sum}), 32'd0);
        chk("abort adder drive", 32'({add_a, add_b, add_cin}), 32'd0);
        done_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            done_seen = done_seen | done;
        end
        rst_n = 1'b1;
        repeat (N + 2) begin
            @(negedge clk);
            done_seen = done_seen | done | busy;
        end
        chk("abort no done", 32'(done_seen), 32'd0);
        run_add("post-abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 4'b0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencer that performs WIDTH-bit additions by streaming operands one nibble per clock, LSB nibble first, through an external 4-bit ripple carry adder. It sits directly upstream and downstream of that adder. It drives the adder's A/B/Cin inputs from captured operands and a registered carry. It collects the adder's S/Cout into a WIDTH-bit result with a start/busy/done handshake.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
N (localparam), WIDTH/4, number of nibble steps per addition.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when busy=0
op_a  input  WIDTH  operand A, sampled on the accepting edge
op_b  input  WIDTH  operand B, sampled on the accepting edge
cin  input  1  carry-in, sampled on the accepting edge
busy  output  1  high while an addition is in progress (RUN or DONE)
done  output  1  one-cycle pulse; sum/cout valid
sum  output  WIDTH  registered result
cout  output  1  registered final carry-out
add_a  output  4  to adder A
add_b  output  4  to adder B
add_cin  output  1  to adder Cin
add_s  input  4  from adder S
add_cout  input  1  from adder Cout

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values: state=IDLE, idx=0, carry_reg=0, a_reg=b_reg=0, sum=0, cout=0, busy=0, done=0, add_a=add_b=0, add_cin=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: capture op_a, op_b into a_reg, b_reg; carry_reg<=cin; idx<=0; state<=RUN.
  - sum and cout are not cleared at this point.
- RUN, combinational outputs:
  - add_a = a_reg[4*idx+:4]
  - add_b = b_reg[4*idx+:4]
  - add_cin = carry_reg
- RUN, each edge:
  - sum[4*idx+:4] <= add_s; carry_reg <= add_cout.
  - If idx==N-1: cout<=add_cout and state<=DONE. Otherwise idx<=idx+1.
- RUN lasts exactly N cycles. The adder path is purely combinational within one cycle; there is no adder pipeline stage.
- DONE: done=1 for exactly one cycle, then state<=IDLE.
- Latency: accepting edge at T → done high during the cycle after edge T+N. The next start is accepted at edge T+N+2 at the earliest.
- Outside RUN, add_a, add_b and add_cin are driven to 0.
- busy = (state != IDLE), decoded from state.
- done is decoded from state==DONE.
- start while busy=1 (RUN or DONE) is ignored. Captured operands are unaffected.
- start held continuously: a new addition is accepted on each IDLE cycle, giving back-to-back operations every N+2 cycles.
- sum and cout:
  - Bits of sum update nibble by nibble during RUN.
  - Both are guaranteed valid from the done cycle onward.
  - Both hold until the next accepted start's RUN overwrites them.
- Arithmetic: {cout,sum} = op_a + op_b + cin, computed modulo 2^(WIDTH+1). Carry propagates between nibbles via carry_reg only.
- Reset mid-operation (rst_n low in any state): immediately return to the reset values. No done pulse is produced. The aborted operation is lost.
- idx is ceil(log2(N)) bits wide. It never exceeds N-1.

Test Plan:
1. Reset: hold rst_n=0 with random inputs → busy=0, done=0, sum=0x0000, cout=0, add_a=0, add_b=0, add_cin=0. Bench uses WIDTH=16 with the real 4-bit adder wired in.
2. op_a=0x1234, op_b=0x1111, cin=0, start pulse at edge T → add_a sequence 4,3,2,1 during RUN; done high only after edge T+4; sum=0x2345, cout=0.
3. op_a=0xFFFF, op_b=0x0001, cin=0 → add_cin sequence 0,1,1,1; sum=0x0000, cout=1 (carry ripples across all nibbles).
4. op_a=0x7FFF, op_b=0x8000, cin=1 → sum=0x0000, cout=1. Repeat with 0xA5A5+0x5A5A, cin=1 → sum=0x0000, cout=1.
5. Start 0x0005+0x0003, then assert start with op_a=0xFFFF one cycle later while busy → ignored; result sum=0x0008, cout=0. Hold start high afterwards: next accepted exactly N+2 cycles after the first acceptance.
6. Start 0x1234+0x1111, drop rst_n during the 2nd RUN cycle → all outputs zero immediately, no done. After release, 0x0001+0x0001 → sum=0x0002, cout=0.
